// File: rtl/shift_count_controller.sv
// Serial timer sequencer: finds PATTERN on data, shifts in a DELAY_W-bit delay, times it, waits for ack.
// Define SHIFT_CTRL_ABORT_EN to add the abort input.
module shift_count_controller #(
   parameter logic [3:0] PATTERN          = 4'b1101,
   parameter int         DELAY_W          = 4,
   parameter int         CYCLES_PER_COUNT = 1000
) (
   input  logic               clk,
   input  logic               reset,
`ifdef SHIFT_CTRL_ABORT_EN
   input  logic               abort,
`endif
   input  logic               data,
   input  logic               ack,
   output logic               shift_ena,
   output logic               counting,
   output logic               done,
   output logic [DELAY_W-1:0] count
);

   localparam int CW = $clog2(CYCLES_PER_COUNT + 1);
   localparam int BW = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_COUNT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DELAY_W - 1);

   typedef enum logic [1:0] {
      SEARCH   = 2'd0,
      SHIFT    = 2'd1,
      COUNT    = 2'd2,
      WAIT_ACK = 2'd3
   } state_t;

   state_t             state_r, state_s;
   logic [1:0]         det_r, det_s;
   logic [DELAY_W-1:0] delay_r, delay_s;
   logic [BW-1:0]      bit_r, bit_s;
   logic [CW-1:0]      cyc_r, cyc_s;
   logic [DELAY_W-1:0] count_r, count_s;
   logic               shift_ena_r, counting_r, done_r;
   logic               shift_ena_s, counting_s, done_s;
   logic               abort_s;
   logic [2:0]         prefix_s;
   logic [DELAY_W-1:0] shifted_s;

   // Longest PATTERN prefix that is a suffix of (matched prefix of length ph, then din); 4 = full match.
   function automatic logic [2:0] prefix_next(input logic [1:0] ph, input logic din);
      logic [3:0] s;
      logic [3:0] r;
      logic [2:0] best;
      s = PATTERN;
      s[2'd3 - ph] = din;
      r = s >> (2'd3 - ph);
      best = 3'd0;
      for (int l = 1; l <= 4; l++) begin
         if ((l <= int'(ph) + 1) && (((r ^ (PATTERN >> (4 - l))) & ~(4'hF << l)) == 4'h0)) begin
            best = 3'(l);
         end else begin
            best = best;
         end
      end
      return best;
   endfunction

`ifdef SHIFT_CTRL_ABORT_EN
   assign abort_s = abort;
`else
   assign abort_s = 1'b0;
`endif

   assign prefix_s  = prefix_next(det_r, data);
   assign shifted_s = DELAY_W'({delay_r, data});

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= SEARCH;
         det_r   <= 2'd0;
         delay_r <= '0;
         bit_r   <= '0;
         cyc_r   <= '0;
         count_r <= '0;
      end else begin
         state_r <= state_s;
         det_r   <= det_s;
         delay_r <= delay_s;
         bit_r   <= bit_s;
         cyc_r   <= cyc_s;
         count_r <= count_s;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_s = state_r;
      det_s   = det_r;
      delay_s = delay_r;
      bit_s   = bit_r;
      cyc_s   = cyc_r;
      count_s = count_r;
      case (state_r)
         SEARCH: begin
            if (abort_s) begin
               det_s = 2'd0;
            end else if (prefix_s == 3'd4) begin
               state_s = SHIFT;
               det_s   = 2'd0;
               delay_s = '0;
               bit_s   = '0;
            end else begin
               det_s = prefix_s[1:0];
            end
         end
         SHIFT: begin
            if (abort_s) begin
               state_s = SEARCH;
               det_s   = 2'd0;
               count_s = '0;
               bit_s   = '0;
            end else if (bit_r == BIT_LAST) begin
               state_s = COUNT;
               delay_s = shifted_s;
               count_s = shifted_s;
               cyc_s   = '0;
               bit_s   = '0;
            end else begin
               delay_s = shifted_s;
               bit_s   = bit_r + BW'(1);
            end
         end
         COUNT: begin
            if (abort_s) begin
               state_s = SEARCH;
               det_s   = 2'd0;
               count_s = '0;
               cyc_s   = '0;
            end else if (cyc_r == CYC_LAST) begin
               cyc_s = '0;
               if (count_r == '0) begin
                  state_s = WAIT_ACK;
               end else begin
                  count_s = count_r - DELAY_W'(1);
               end
            end else begin
               cyc_s = cyc_r + CW'(1);
            end
         end
         WAIT_ACK: begin
            if (abort_s || ack) begin
               state_s = SEARCH;
               det_s   = 2'd0;
               count_s = '0;
            end else begin
               state_s = WAIT_ACK;
            end
         end
         default: begin
            state_s = SEARCH;
            det_s   = 2'd0;
            delay_s = '0;
            bit_s   = '0;
            cyc_s   = '0;
            count_s = '0;
         end
      endcase
   end

   // Output decode from the upcoming state, so the flags are registered yet aligned with the state.
   always_comb begin
      shift_ena_s = 1'b0;
      counting_s  = 1'b0;
      done_s      = 1'b0;
      case (state_s)
         SHIFT:    shift_ena_s = 1'b1;
         COUNT:    counting_s  = 1'b1;
         WAIT_ACK: done_s      = 1'b1;
         default:  shift_ena_s = 1'b0;
      endcase
   end

   // Output flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_ena_r <= 1'b0;
         counting_r  <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         shift_ena_r <= shift_ena_s;
         counting_r  <= counting_s;
         done_r      <= done_s;
      end
   end

   assign shift_ena = shift_ena_r;
   assign counting  = counting_r;
   assign done      = done_r;
   assign count     = count_r;

endmodule

// File: tb/tb_shift_count_controller.sv
// Bench for shift_count_controller: directed scenarios plus random traffic against a transaction-level model.
// Covers abort when SHIFT_CTRL_ABORT_EN is defined.
module tb_shift_count_controller;
   localparam int DW  = 4;
   localparam int CPC = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          data = 1'b0;
   logic          ack = 1'b0;
`ifdef SHIFT_CTRL_ABORT_EN
   logic          abort = 1'b0;
`endif
   logic          shift_ena, counting, done;
   logic [DW-1:0] count;

   int checks = 0;
   int errors = 0;

   // model: mode 0 search, 1 loading delay, 2 timing, 3 waiting for ack
   int m_mode = 0;
   bit m_hist[$];
   bit m_bits[$];
   int m_left = 0;
   int shift_seen, count_seen, done_seen;

   shift_count_controller #(
      .PATTERN(4'b1101), .DELAY_W(DW), .CYCLES_PER_COUNT(CPC)
   ) dut (
      .clk(clk),
      .reset(reset),
`ifdef SHIFT_CTRL_ABORT_EN
      .abort(abort),
`endif
      .data(data),
      .ack(ack),
      .shift_ena(shift_ena),
      .counting(counting),
      .done(done),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_edge(bit r, bit d, bit a, bit ab);
      int v;
      if (r) begin
         m_mode = 0; m_hist.delete(); m_bits.delete(); m_left = 0;
      end else if (ab) begin
         m_mode = 0; m_hist.delete(); m_left = 0;
      end else begin
         case (m_mode)
            0: begin
               m_hist.push_back(d);
               if (m_hist.size() > 4) void'(m_hist.pop_front());
               if (m_hist.size() == 4 && {m_hist[0], m_hist[1], m_hist[2], m_hist[3]} == 4'b1101) begin
                  m_mode = 1; m_hist.delete(); m_bits.delete();
               end
            end
            1: begin
               m_bits.push_back(d);
               if (m_bits.size() == DW) begin
                  v = 0;
                  foreach (m_bits[i]) v = v * 2 + int'(m_bits[i]);
                  m_left = (v + 1) * CPC;
                  m_mode = 2;
               end
            end
            2: begin
               m_left--;
               if (m_left == 0) m_mode = 3;
            end
            3: if (a) begin
               m_mode = 0; m_hist.delete();
            end
            default: m_mode = 0;
         endcase
      end
   endfunction

   task automatic step(input bit d, input bit a, input bit r, input bit ab);
      int exp_count;
      data  = d;
      ack   = a;
      reset = r;
`ifdef SHIFT_CTRL_ABORT_EN
      abort = ab;
`endif
      @(posedge clk);
      model_edge(r, d, a, ab);
      #1;
      exp_count = (m_mode == 2) ? (m_left - 1) / CPC : 0;
      check_eq("shift_ena", 32'(shift_ena), 32'(m_mode == 1));
      check_eq("counting", 32'(counting), 32'(m_mode == 2));
      check_eq("done", 32'(done), 32'(m_mode == 3));
      check_eq("count", 32'(count), 32'(exp_count));
      if (shift_ena === 1'b1) shift_seen++;
      if (counting === 1'b1) count_seen++;
      if (done === 1'b1) done_seen++;
   endtask

   task automatic send(input bit [3:0] v);
      for (int i = 3; i >= 0; i--) step(v[i], 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic clear_tally();
      shift_seen = 0; count_seen = 0; done_seen = 0;
   endtask

   initial begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);

      // Basic run with delay 5
      clear_tally();
      send(4'b1101); send(4'b0101); idle(26);
      check_eq("shift_len", 32'(shift_seen), 32'd4);
      check_eq("count_len_5", 32'(count_seen), 32'd24);
      idle(100);
      check_eq("done_held", 32'(done), 32'd1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("done_fall", 32'(done), 32'd0);

      // No prefix credit from the ack edge, then delay 0
      clear_tally();
      step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
      check_eq("no_credit", 32'(shift_seen), 32'd0);
      send(4'b1101); send(4'b0000); idle(6);
      check_eq("count_len_0", 32'(count_seen), 32'd4);
      step(1'b0, 1'b1, 1'b0, 1'b0);

      // Overlapping start, delay 15
      clear_tally();
      step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("overlap_rise", 32'(shift_ena), 32'd1);
      send(4'b1111); idle(70);
      check_eq("count_len_15", 32'(count_seen), 32'd64);
      step(1'b0, 1'b1, 1'b0, 1'b0);

      // Near-miss pattern
      clear_tally();
      step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(6);
      check_eq("near_miss", 32'(shift_seen), 32'd0);

      // Reset mid-SHIFT and mid-COUNT, then a clean restart with delay 1
      send(4'b1101); step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("rst_shift", 32'(shift_ena), 32'd0);
      send(4'b1101); send(4'b0011); idle(5);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("rst_count", 32'(counting), 32'd0);
      clear_tally();
      send(4'b1101); send(4'b0001); idle(10);
      check_eq("count_len_1", 32'(count_seen), 32'd8);
      step(1'b0, 1'b1, 1'b0, 1'b0);

`ifdef SHIFT_CTRL_ABORT_EN
      clear_tally();
      send(4'b1101); send(4'b0010); idle(3);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("abort_count", 32'(counting), 32'd0);
      idle(20);
      check_eq("abort_no_done", 32'(done_seen), 32'd0);
      send(4'b1101); send(4'b0000); idle(5);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check_eq("abort_ack", 32'(done), 32'd0);
`endif

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         bit ab;
         ab = 1'b0;
`ifdef SHIFT_CTRL_ABORT_EN
         ab = ($urandom % 150 == 0);
`endif
         step(1'($urandom % 2), 1'($urandom % 6 == 0), 1'($urandom % 300 == 0), ab);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
